// File: rtl/arith_pkg.sv
// Shared arithmetic-library types and helpers: the sequential multiplier state
// encoding and a width-generic conditional two's-complement negate.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } seq_mult_state_t;

  // Widest operand the helper handles; callers size-cast the result, which is
  // exact because negation is taken modulo 2^n.
  localparam int ARITH_MAX_W = 64;

  function automatic logic [ARITH_MAX_W-1:0] abs_val(input logic [ARITH_MAX_W-1:0] x,
                                                     input logic                   neg);
    logic [ARITH_MAX_W-1:0] r;
    if (neg) begin
      r = ~x + 64'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle of the sequential multiplier.
interface seq_multiplier_if #(parameter int WIDTH = 8);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: magnitude capture, WIDTH+1-bit add with carry, joint
// right shift of {carry, accumulator, multiplier}, and final sign restore.
module seq_mult_datapath
  import arith_pkg::*;
#(
  parameter int WIDTH = 8   // 2..32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = ARITH_MAX_W;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH:0]   add_s;
  logic [PW-1:0]    full_s;

  // Next-state datapath: load magnitudes, iterate, or latch the signed result.
  always_comb begin
    add_s     = {1'b0, acc_q} + ({1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}});
    full_s    = {add_s, mplier_q[WIDTH-1:1]};
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (load) begin
      mcand_d  = WIDTH'(abs_val(MW'(a), is_signed & a[WIDTH-1]));
      mplier_d = WIDTH'(abs_val(MW'(b), is_signed & b[WIDTH-1]));
      acc_d    = {WIDTH{1'b0}};
      neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_d    = add_s[WIDTH:1];
      mplier_d = {add_s[0], mplier_q[WIDTH-1:1]};
      // full_s already holds the final shifted magnitude on the last step
      if (finish) begin
        product_d = PW'(abs_val(MW'(full_s), neg_q));
      end else begin
        product_d = product_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      neg_q     <= 1'b0;
      product_q <= {PW{1'b0}};
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/seq_multiplier.sv
// WIDTH-cycle shift-add multiplier with valid/ready on both sides and a
// per-transaction signed/unsigned mode.
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_multiplier_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  seq_mult_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            load_s, step_s, finish_s;

  // Next-state, counter and datapath strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load_s  = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (cnt_q == LAST) begin
          finish_s = 1'b1;
          cnt_d    = {CW{1'b0}};
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    // Handshake outputs are registered copies of the next-state decode
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // FSM and handshake output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .step      (step_s),
    .finish    (finish_s),
    .a         (bus.a),
    .b         (bus.b),
    .is_signed (bus.is_signed),
    .product   (bus.product)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and table-driven bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(4)) if4();
  seq_multiplier_if #(.WIDTH(8)) if8();

  seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x;
    int y;
    int r;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    r = x * y;
    return r[15:0];
  endfunction

  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [15:0] p, output int lat);
    int n;
    if8.a = a; if8.b = b; if8.is_signed = s;
    if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    n = 0;
    while (if8.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    lat = n;
    p   = if8.product;
    tick();
  endtask

  task automatic txn4(input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p, output int lat);
    int n;
    if4.a = a; if4.b = b; if4.is_signed = 1'b0;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    n = 0;
    while (if4.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    lat = n;
    p   = if4.product;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic [15:0] p8;
    logic [7:0]  p4;
    int          lat;
    int          n;
    logic [15:0] expq[$];
    logic        prev_ready;
    int          cyc, last_acc, got;

    vecs[0] = '{a: 8'h80, b: 8'h80, s: 1'b1, p: 16'h4000};
    vecs[1] = '{a: 8'h80, b: 8'h01, s: 1'b1, p: 16'hFF80};
    vecs[2] = '{a: 8'hFF, b: 8'h02, s: 1'b1, p: 16'hFFFE};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, p: 16'hFE01};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, s: 1'b1, p: 16'h0001};
    vecs[5] = '{a: 8'h7F, b: 8'h80, s: 1'b1, p: 16'hC080};
    vecs[6] = '{a: 8'h00, b: 8'hFF, s: 1'b0, p: 16'h0000};

    rst = 1'b1;
    if4.in_valid = 1'b0; if4.a = 4'h0; if4.b = 4'h0; if4.is_signed = 1'b0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.is_signed = 1'b0; if8.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("rst_out_valid", 32'(if8.out_valid), 32'd0);
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_product", 32'(if8.product), 32'd0);
    check("rst_in_ready_w4", 32'(if4.in_ready), 32'd1);
    rst = 1'b0;

    // WIDTH=4 exhaustive unsigned
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        txn4(ai[3:0], bi[3:0], p4, lat);
        check($sformatf("w4_prod_%0d_%0d", ai, bi), 32'(p4), 32'(ai * bi));
        check($sformatf("w4_lat_%0d_%0d", ai, bi), 32'(lat), 32'd4);
      end
    end

    // WIDTH=8 directed vectors
    for (int i = 0; i < 7; i++) begin
      txn8(vecs[i].a, vecs[i].b, vecs[i].s, p8, lat);
      check($sformatf("vec%0d_prod", i), 32'(p8), 32'(vecs[i].p));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
    end

    // Back-pressure with an ignored in_valid pulse while DONE
    if8.a = 8'd12; if8.b = 8'd13; if8.is_signed = 1'b0;
    if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    tick();
    if8.in_valid = 1'b0;
    n = 0;
    while (if8.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check("bp_lat", 32'(n), 32'd8);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_prod_c%0d", c), 32'(if8.product), 32'h009C);
      check($sformatf("bp_in_ready_c%0d", c), 32'(if8.in_ready), 32'd0);
      check($sformatf("bp_out_valid_c%0d", c), 32'(if8.out_valid), 32'd1);
      if8.in_valid = (c == 1);
      if8.a = 8'd3; if8.b = 8'd3;
      tick();
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(if8.in_ready), 32'd1);
    check("bp_release_busy", 32'(if8.busy), 32'd0);
    check("bp_release_prod", 32'(if8.product), 32'h009C);
    tick();
    check("bp_no_late_accept", 32'(if8.in_ready), 32'd1);

    // Reset during the third CALC cycle of 12x13
    if8.a = 8'd12; if8.b = 8'd13; if8.is_signed = 1'b0; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick();
    tick();
    check("midrst_busy_before", 32'(if8.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(if8.in_ready), 32'd1);
    check("midrst_out_valid", 32'(if8.out_valid), 32'd0);
    check("midrst_busy", 32'(if8.busy), 32'd0);
    check("midrst_product", 32'(if8.product), 32'd0);
    tick();
    rst = 1'b0;
    txn8(8'd3, 8'd5, 1'b0, p8, lat);
    check("post_rst_prod", 32'(p8), 32'd15);
    check("post_rst_lat", 32'(lat), 32'd8);

    // Back-to-back random operands with in_valid held high
    cyc = 0; last_acc = -1; got = 0;
    if8.out_ready = 1'b1;
    if8.a = 8'($urandom_range(0, 255)); if8.b = 8'($urandom_range(0, 255));
    if8.is_signed = 1'($urandom_range(0, 1));
    if8.in_valid = 1'b1;
    while (got < 12 && cyc < 400) begin
      prev_ready = if8.in_ready;
      tick();
      cyc++;
      if (prev_ready) begin
        if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
        expq.push_back(model(if8.a, if8.b, if8.is_signed));
        if8.a = 8'($urandom_range(0, 255)); if8.b = 8'($urandom_range(0, 255));
        if8.is_signed = 1'($urandom_range(0, 1));
      end
      if (if8.out_valid) begin
        if (expq.size() == 0) begin
          check("b2b_unexpected_result", 32'(if8.out_valid), 32'd0);
        end else begin
          check($sformatf("b2b_prod%0d", got), 32'(if8.product), 32'(expq.pop_front()));
        end
        got++;
      end
    end
    if8.in_valid = 1'b0;
    check("b2b_result_count", 32'(got), 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier: the successor to the 4-bit combinational array multiplier. It is generalised to WIDTH-bit operands, adds a per-transaction signed/unsigned mode and valid/ready handshakes on both sides, and trades area for a WIDTH-cycle latency. It sits in the arithmetics library as the default multiplier for datapaths wider than 4 bits, where a full array is too large.

## Interface
- WIDTH, default 8: operand width in bits, minimum 2; the product is 2*WIDTH bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  the operand set on a, b and is_signed is valid.
- in_ready  out  1  the block can accept operands; high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = both operands are two's complement; 0 = both are unsigned.
- out_valid  out  1  product is valid; high only in DONE.
- out_ready  in  1  the downstream consumer takes the product.
- product  out  2*WIDTH  result: two's complement when is_signed was 1, unsigned otherwise.
- busy  out  1  high in CALC or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - CALC: iteration counter 0..WIDTH-1.
  - DONE: out_valid=1.
- Accept: in_valid and in_ready high at a rising edge (IDLE). On that edge:
  - capture the operand magnitudes: |a| and |b| when is_signed=1, raw values otherwise;
  - capture neg = is_signed & (a[MSB] ^ b[MSB]);
  - clear the accumulator and the counter;
  - go to CALC.
- CALC, one iteration per edge:
  - if the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator; this add is WIDTH+1 bits wide and keeps the carry;
  - then shift the {carry, accumulator, multiplier} right by one.
  - On the iteration with counter = WIDTH-1, load product with the accumulator, negated if neg is set, and go to DONE.
- Magnitude rule: the most negative operand (-2^(WIDTH-1)) has magnitude 2^(WIDTH-1). This fits in WIDTH unsigned bits, so it needs no special case. (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits in the signed product.
- DONE: product and out_valid hold until out_valid and out_ready are both high at an edge, then go to IDLE. There is no bypass: a new operand set is accepted at the earliest one edge after the handoff.
- in_valid while busy: ignored (in_ready=0). Operands need not be held stable after the accept edge.
- Zero operands: no early exit; latency is always WIDTH iterations.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0, state=IDLE, counter=0.
- Latency: accept at edge k; out_valid rises after edge k+WIDTH. Minimum transaction period is WIDTH+2 cycles.
- Reset mid-operation (CALC or DONE): the outputs immediately take their reset values and the result in progress is discarded. The first accept after reset deassertion is possible at the next edge.
- out_ready held high on entering DONE: out_valid is high for exactly one cycle.
- Handshake outputs are driven from registers only; there is no combinational path from in_valid or out_ready to any output.

## Structure
- Package arith_pkg:
  - the state enum seq_mult_state_t (IDLE, CALC, DONE);
  - the function abs_val, the WIDTH-generic conditional negate.
- One sub-module is natural: seq_mult_datapath. It holds the accumulator, the multiplier shift register, the adder and the final negate, driven by load/step/finish strobes from the FSM in seq_multiplier.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- WIDTH=4, unsigned, exhaustive 16x16 with out_ready=1 -> every product equals a*b; out_valid comes 4 cycles after each accept.
- WIDTH=8, signed: a=0x80, b=0x80 -> 0x4000; a=0x80, b=0x01 -> 0xFF80; a=0xFF, b=0x02 -> 0xFFFE.
- WIDTH=8, unsigned: a=0xFF, b=0xFF -> 0xFE01; the same bits with is_signed=1 -> 0x0001.
- Back-pressure: out_ready held low for 5 cycles after DONE -> product stable and in_ready=0 throughout; a second in_valid pulse during this time is not accepted.
- Reset asserted on the 3rd CALC cycle of 12x13 -> outputs go to reset values immediately; a following 3x5 returns 15 with normal latency.
- Back-to-back random signed and unsigned operand pairs with in_valid held high -> each result matches the model, and accepts are spaced exactly WIDTH+2 cycles apart.
